pixel_unpacker: RTL and testbench
=================================

// Module: pixel_unpacker
// PURPOSE
//  Receiving end of the 32-bit AXI-Stream video interface driven by the pixel packer. Unpacks
//  3 words into 4 RGB888 pixels, tags each pixel with x/y, and checks SOF (tuser) and EOL
//  (tlast) framing. Used in-fabric as a frame checker or sink and as the bench-side monitor
//  for pixel_generator.
// PARAMETERS
//  X_SIZE  640  pixels per line; must be a multiple of 4
//  Y_SIZE  480  lines per frame
// PORTS
//  aclk             in   1   clock for all logic
//  aresetn          in   1   synchronous reset, active-low
//  in_stream_tdata  in   32  packed pixel bytes
//  in_stream_tkeep  in   4   ignored
//  in_stream_tlast  in   1   end of line; expected on the last word of each line
//  in_stream_tuser  in   1   start of frame; expected on the first word of each frame
//  in_stream_tvalid in   1   word valid
//  in_stream_tready out  1   word accepted when tvalid & tready
//  r, g, b          out  8   pixel colour
//  x                out  10  pixel column
//  y                out  9   pixel row
//  pix_valid        out  1   pixel output valid
//  pix_ready        in   1   downstream ready; a pixel transfers when pix_valid & pix_ready
//  frame_done       out  1   1-cycle pulse when the pixel at (X_SIZE-1,Y_SIZE-1) transfers
//  sof_err          out  1   1-cycle pulse on an SOF framing error
//  eol_err          out  1   1-cycle pulse on an EOL framing error
//  frame_count      out  16  completed frames; wraps at 0xFFFF->0
// BEHAVIOUR
//  Clock and reset:
//  - Single clock aclk; synchronous, active-low reset aresetn.
//  - In reset: state=HUNT, phase=0, x=y=0, pix_valid=0, error pulses=0, frame_done=0,
//    frame_count=0, carry=0, tready=0.
//  - Reset mid-frame discards all held data and returns to HUNT.
//  Packing (pixel = {r,g,b}; stream is little-endian bytes, 3 bytes per pixel):
//  - w0 = {p1[7:0],  p0[23:0]}
//  - w1 = {p2[15:0], p1[23:8]}
//  - w2 = {p3[23:0], p2[23:16]}
//  - A 16-bit carry register holds leftover bytes. phase (0..2) counts the word within the group.
//  HUNT:
//  - tready=1; words are discarded until a word arrives with tuser=1.
//  - That word is processed as phase 0 at (0,0) and state moves to RUN.
//  RUN:
//  - Output register: one pixel, plus one second-pixel hold register.
//  - tready = ~pix_valid | pix_ready, and 0 while the hold register is full.
//  - A phase-0 or phase-1 word emits 1 pixel. A phase-2 word emits p2 first, with p3 in hold.
//  - Output data (r,g,b,x,y) is held stable while pix_valid & ~pix_ready.
//  - Latency: a pixel is visible 1 cycle after its word is accepted. Sustained rate is
//    4 pixels per 4 cycles.
//  - x increments per transferred pixel. At X_SIZE-1, x wraps to 0 and y increments.
//    At the last pixel, y wraps to 0, frame_done pulses and frame_count increments.
//  SOF check (accepted word in RUN):
//  - tuser=1 when not at frame start: sof_err pulses; held/carry data is dropped; the word is
//    restarted as phase 0 at (0,0) (resync).
//  - tuser=0 on the expected first word of a frame: sof_err pulses; the word is dropped;
//    state goes to HUNT.
//  EOL check (accepted word in RUN):
//  - tlast is expected iff phase=2 and the group's first pixel x = X_SIZE-4.
//  - On mismatch, eol_err pulses. Counting continues from the pixel count; there is no resync.
//  Simultaneous conditions:
//  - A word may be accepted in the same cycle the previous pixel transfers.
//  - A single word can raise both sof_err and eol_err in the same cycle.
// TESTING
//  1 Reset: hold aresetn=0 for 3 cycles, then release -> all outputs 0; next cycle tready=1,
//    pix_valid=0.
//  2 Unpack: words 0x66112233 (tuser=1), 0x88994455, 0xAABBCC77 with pix_ready=1 ->
//    112233@(0,0), 445566@(1,0), 778899@(2,0), AABBCC@(3,0); tready=0 for exactly 1 cycle
//    after w2.
//  3 Full frame: 640x480 frame with correct tuser/tlast and random pix_ready ->
//    307200 pixels in order, one frame_done, frame_count=1, no error pulses.
//  4 Backpressure: pix_ready=0 for 10 cycles mid-line -> pix_valid stays 1 with r/g/b/x/y
//    stable; tready=0; no word lost.
//  5 Framing: tlast missing on line 5 -> one eol_err and following pixels still correct;
//    tuser=1 at word 100 -> sof_err and restart at (0,0).
//  6 Hunt: 7 words with tuser=0 after reset -> all accepted, no pixels out; the next tuser=1
//    word -> pixel at (0,0).

Source files
------------

// File: rtl/pixel_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : pixel_unpacker
// Description : Receive side of the 32-bit AXI-Stream video link. Every three
//               stream words carry four RGB888 pixels in little-endian byte
//               order. This block unpacks them, tags each pixel with its x/y
//               position and checks frame framing:
//                 - SOF: tuser must be high on the first word of each frame.
//                 - EOL: tlast must be high on the last word of each line.
//               A single output register and a single second-pixel hold
//               register sit between the stream and the pixel interface.
//
// Ports       : aclk, aresetn          clock, synchronous active-low reset
//               in_stream_t*           AXI-Stream slave (tkeep is ignored)
//               r, g, b, x, y          pixel colour and position
//               pix_valid / pix_ready  pixel handshake
//               frame_done             pulse when the last pixel of a frame
//                                      transfers
//               sof_err, eol_err       framing error pulses
//               frame_count            completed frames, wraps at 16 bits
//
// Revision    : 1.0  initial release
// ============================================================================
module pixel_unpacker #(
   parameter int X_SIZE = 640,
   parameter int Y_SIZE = 480
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [31:0] in_stream_tdata,
   input  logic [3:0]  in_stream_tkeep,
   input  logic        in_stream_tlast,
   input  logic        in_stream_tuser,
   input  logic        in_stream_tvalid,
   output logic        in_stream_tready,
   output logic [7:0]  r,
   output logic [7:0]  g,
   output logic [7:0]  b,
   output logic [9:0]  x,
   output logic [8:0]  y,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic        frame_done,
   output logic        sof_err,
   output logic        eol_err,
   output logic [15:0] frame_count
);

   localparam logic [9:0] c_X_LAST     = 10'(X_SIZE - 1);
   localparam logic [9:0] c_X_GRP_LAST = 10'(X_SIZE - 4);
   localparam logic [8:0] c_Y_LAST     = 9'(Y_SIZE - 1);

   localparam logic [0:0] c_HUNT = 1'b0;
   localparam logic [0:0] c_RUN  = 1'b1;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [0:0]  r_state;
   logic [0:0]  w_state_next;
   logic        r_en;            // holds tready low until the first clock after reset
   logic [1:0]  r_phase;         // word index within the current 3-word group
   logic [15:0] r_carry;         // leftover bytes from the previous word
   logic [9:0]  r_wx;            // x of the current group's first pixel
   logic [8:0]  r_wy;            // y of the current group
   logic        r_hold_valid;
   logic [23:0] r_hold_pix;
   logic [9:0]  r_hold_x;
   logic [8:0]  r_hold_y;
   logic        r_pix_valid;
   logic [23:0] r_pix;
   logic [9:0]  r_x;
   logic [8:0]  r_y;
   logic        r_frame_done;
   logic        r_sof_err;
   logic        r_eol_err;
   logic [15:0] r_frame_count;

   // ------------------------------------------------------------------------
   // Handshake and framing decode
   // ------------------------------------------------------------------------
   logic        w_accept;
   logic        w_xfer;
   logic        w_run;
   logic        w_frame_start;
   logic        w_sof_resync;
   logic        w_sof_drop;
   logic        w_hunt_start;
   logic        w_restart;
   logic        w_proc;
   logic [1:0]  w_eff_phase;
   logic [9:0]  w_eff_wx;
   logic [8:0]  w_eff_wy;
   logic        w_eol_expected;
   logic        w_eol_err;
   logic        w_last_pix;
   logic        w_unused;

   assign w_unused      = ^in_stream_tkeep;

   assign w_accept      = in_stream_tvalid & in_stream_tready;
   assign w_xfer        = r_pix_valid & pix_ready;
   assign w_run         = (r_state == c_RUN);
   assign w_frame_start = (r_phase == 2'd0) && (r_wx == 10'd0) && (r_wy == 9'd0);

   // tuser where a mid-frame word was expected: restart the frame on this word
   assign w_sof_resync  = w_accept & w_run & in_stream_tuser & ~w_frame_start;
   // tuser missing on the first word of a frame: discard the word and hunt
   assign w_sof_drop    = w_accept & w_run & ~in_stream_tuser & w_frame_start;
   assign w_hunt_start  = w_accept & ~w_run & in_stream_tuser;
   assign w_restart     = w_hunt_start | w_sof_resync;
   assign w_proc        = w_hunt_start | (w_accept & w_run & ~w_sof_drop);

   // A restarted word is treated as phase 0 at (0,0); the old carry is unused
   assign w_eff_phase   = w_restart ? 2'd0  : r_phase;
   assign w_eff_wx      = w_restart ? 10'd0 : r_wx;
   assign w_eff_wy      = w_restart ? 9'd0  : r_wy;

   assign w_eol_expected = (w_eff_phase == 2'd2) && (w_eff_wx == c_X_GRP_LAST);
   assign w_eol_err      = w_accept & w_run & (in_stream_tlast != w_eol_expected);

   assign w_last_pix     = w_xfer && (r_x == c_X_LAST) && (r_y == c_Y_LAST);

   // ------------------------------------------------------------------------
   // Byte unpacking. Pixel = {r,g,b}; stream bytes are little-endian.
   //   w0 = {p1[7:0],  p0[23:0]}
   //   w1 = {p2[15:0], p1[23:8]}
   //   w2 = {p3[23:0], p2[23:16]}
   // ------------------------------------------------------------------------
   logic [23:0] w_pix_a;
   logic [23:0] w_pix_b;
   logic [15:0] w_carry_next;
   logic [9:0]  w_x_a;

   always_comb begin
      w_pix_a      = '0;
      w_pix_b      = '0;
      w_carry_next = '0;
      case (w_eff_phase)
         2'd0: begin
            w_pix_a      = in_stream_tdata[23:0];
            w_carry_next = {8'h00, in_stream_tdata[31:24]};
         end
         2'd1: begin
            w_pix_a      = {in_stream_tdata[15:0], r_carry[7:0]};
            w_carry_next = in_stream_tdata[31:16];
         end
         default: begin
            w_pix_a      = {in_stream_tdata[7:0], r_carry[15:0]};
            w_pix_b      = in_stream_tdata[31:8];
         end
      endcase
   end

   assign w_x_a = w_eff_wx + {8'd0, w_eff_phase};

   // Position of the next group once a phase-2 word completes the current one
   logic [9:0] w_wx_next;
   logic [8:0] w_wy_next;

   always_comb begin
      w_wx_next = w_eff_wx + 10'd4;
      w_wy_next = w_eff_wy;
      if (w_eff_wx == c_X_GRP_LAST) begin
         w_wx_next = 10'd0;
         w_wy_next = (w_eff_wy == c_Y_LAST) ? 9'd0 : w_eff_wy + 9'd1;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state <= c_HUNT;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_HUNT:  if (w_hunt_start) w_state_next = c_RUN;
         default: if (w_sof_drop)   w_state_next = c_HUNT;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs. In HUNT the output register is always empty (a word is only
   // accepted in RUN while the output is draining), so tready can stay high.
   // ------------------------------------------------------------------------
   always_comb begin
      in_stream_tready = 1'b0;
      case (r_state)
         c_HUNT:  in_stream_tready = r_en;
         default: in_stream_tready = r_en & ~r_hold_valid & (~r_pix_valid | pix_ready);
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------------
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_en          <= 1'b0;
         r_phase       <= 2'd0;
         r_carry       <= '0;
         r_wx          <= '0;
         r_wy          <= '0;
         r_hold_valid  <= 1'b0;
         r_hold_pix    <= '0;
         r_hold_x      <= '0;
         r_hold_y      <= '0;
         r_pix_valid   <= 1'b0;
         r_pix         <= '0;
         r_x           <= '0;
         r_y           <= '0;
         r_frame_done  <= 1'b0;
         r_sof_err     <= 1'b0;
         r_eol_err     <= 1'b0;
         r_frame_count <= '0;
      end else begin
         r_en         <= 1'b1;
         r_frame_done <= w_last_pix;
         r_sof_err    <= w_sof_resync | w_sof_drop;
         r_eol_err    <= w_eol_err;

         if (w_last_pix) begin
            r_frame_count <= r_frame_count + 16'd1;
         end

         if (w_sof_drop) begin
            r_phase <= 2'd0;
            r_carry <= '0;
         end

         if (w_proc) begin
            // Accepting a word implies the hold register is empty and the
            // output register is empty or draining this cycle.
            r_pix       <= w_pix_a;
            r_x         <= w_x_a;
            r_y         <= w_eff_wy;
            r_pix_valid <= 1'b1;
            r_carry     <= w_carry_next;
            if (w_eff_phase == 2'd2) begin
               r_phase      <= 2'd0;
               r_wx         <= w_wx_next;
               r_wy         <= w_wy_next;
               r_hold_valid <= 1'b1;
               r_hold_pix   <= w_pix_b;
               r_hold_x     <= w_eff_wx + 10'd3;
               r_hold_y     <= w_eff_wy;
            end else begin
               r_phase <= w_eff_phase + 2'd1;
               r_wx    <= w_eff_wx;
               r_wy    <= w_eff_wy;
            end
         end else if (r_hold_valid && (w_xfer || !r_pix_valid)) begin
            r_pix        <= r_hold_pix;
            r_x          <= r_hold_x;
            r_y          <= r_hold_y;
            r_pix_valid  <= 1'b1;
            r_hold_valid <= 1'b0;
         end else if (w_xfer) begin
            r_pix_valid <= 1'b0;
         end
      end
   end

   assign r           = r_pix[23:16];
   assign g           = r_pix[15:8];
   assign b           = r_pix[7:0];
   assign x           = r_x;
   assign y           = r_y;
   assign pix_valid   = r_pix_valid;
   assign frame_done  = r_frame_done;
   assign sof_err     = r_sof_err;
   assign eol_err     = r_eol_err;
   assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_pixel_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_unpacker
// Description : Self-checking bench for pixel_unpacker. Directed sequences for
//               reset, unpack timing, backpressure and hunt, plus a table of
//               randomised stream scenarios compared against a byte-stream
//               packing model. Frame geometry is reduced to 16x10.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pixel_unpacker;

   localparam int XS  = 16;
   localparam int YS  = 10;
   localparam int WPL = XS * 3 / 4;   // words per line
   localparam int WPF = WPL * YS;     // words per frame
   localparam int PPF = XS * YS;      // pixels per frame

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [31:0] in_stream_tdata = '0;
   logic [3:0]  in_stream_tkeep = 4'hF;
   logic        in_stream_tlast = 1'b0;
   logic        in_stream_tuser = 1'b0;
   logic        in_stream_tvalid = 1'b0;
   logic        in_stream_tready;
   logic [7:0]  r, g, b;
   logic [9:0]  x;
   logic [8:0]  y;
   logic        pix_valid;
   logic        pix_ready = 1'b0;
   logic        frame_done, sof_err, eol_err;
   logic [15:0] frame_count;

   always #5 aclk = ~aclk;

   pixel_unpacker #(.X_SIZE(XS), .Y_SIZE(YS)) dut (
      .aclk            (aclk),
      .aresetn         (aresetn),
      .in_stream_tdata (in_stream_tdata),
      .in_stream_tkeep (in_stream_tkeep),
      .in_stream_tlast (in_stream_tlast),
      .in_stream_tuser (in_stream_tuser),
      .in_stream_tvalid(in_stream_tvalid),
      .in_stream_tready(in_stream_tready),
      .r               (r),
      .g               (g),
      .b               (b),
      .x               (x),
      .y               (y),
      .pix_valid       (pix_valid),
      .pix_ready       (pix_ready),
      .frame_done      (frame_done),
      .sof_err         (sof_err),
      .eol_err         (eol_err),
      .frame_count     (frame_count)
   );

   typedef struct {
      logic [31:0] d;
      logic        u;
      logic        l;
   } word_t;

   typedef struct {
      string name;
      int    junk;       // tuser=0 words before the first frame
      int    cut;        // >=0: a frame truncated to this many words comes first
      int    frames;     // complete frames
      int    kill;       // frame index whose tuser is cleared (-1 none)
      int    drop_line;  // line of frame 0 whose tlast is cleared (-1 none)
      int    ready_pct;
      int    gap_pct;
      int    exp_frames;
      int    exp_sof;
      int    exp_eol;
   } scen_t;

   word_t       tx_q[$];
   logic [42:0] exp_q[$];
   logic [42:0] got_q[$];
   int n_tests = 0;
   int n_fail  = 0;
   int cnt_fd, cnt_sof, cnt_eol;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic drive(input logic [31:0] d, input logic u, input logic l, input logic v);
      in_stream_tdata  = d;
      in_stream_tuser  = u;
      in_stream_tlast  = l;
      in_stream_tvalid = v;
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      drive(32'h0, 1'b0, 1'b0, 1'b0);
      pix_ready = 1'b0;
      repeat (3) tick();
      aresetn = 1'b1;
      tick();
   endtask

   // Reference: pixels become a little-endian byte stream, 4 bytes per word.
   task automatic add_frame(input int n_words, input bit kill, input int drop_line, input bit expect_pix);
      logic [23:0] px[PPF];
      logic [7:0]  bs[3*PPF];
      word_t       w;
      int          npix;
      for (int i = 0; i < PPF; i++) begin
         px[i]       = 24'($urandom);
         bs[3*i]     = px[i][7:0];
         bs[3*i + 1] = px[i][15:8];
         bs[3*i + 2] = px[i][23:16];
      end
      for (int k = 0; k < n_words; k++) begin
         w.d = {bs[4*k + 3], bs[4*k + 2], bs[4*k + 1], bs[4*k]};
         w.u = (k == 0) && !kill;
         w.l = ((k % WPL) == WPL - 1) && ((k / WPL) != drop_line);
         tx_q.push_back(w);
      end
      if (expect_pix) begin
         npix = (n_words / 3) * 4 + (n_words % 3);
         for (int i = 0; i < npix; i++)
            exp_q.push_back({px[i], 10'(i % XS), 9'(i / XS)});
      end
   endtask

   task automatic add_junk(input int n);
      word_t w;
      for (int k = 0; k < n; k++) begin
         w.d = $urandom;
         w.u = 1'b0;
         w.l = 1'b0;
         tx_q.push_back(w);
      end
   endtask

   task automatic run_stream(input string nm, input int ready_pct, input int gap_pct, input int budget);
      int idx = 0;
      int cyc = 0;
      bit vld = 0;
      bit acc;
      cnt_fd = 0; cnt_sof = 0; cnt_eol = 0;
      got_q.delete();
      while ((idx < tx_q.size() || pix_valid) && cyc < budget) begin
         if (!vld && idx < tx_q.size() && $urandom_range(99) >= gap_pct) vld = 1;
         if (vld) drive(tx_q[idx].d, tx_q[idx].u, tx_q[idx].l, 1'b1);
         else     in_stream_tvalid = 1'b0;
         pix_ready = ($urandom_range(99) < ready_pct);
         #1;
         acc = vld && in_stream_tready;
         if (pix_valid && pix_ready) got_q.push_back({r, g, b, x, y});
         tick();
         if (acc) begin
            idx++;
            vld = 0;
         end
         cnt_fd  += int'(frame_done);
         cnt_sof += int'(sof_err);
         cnt_eol += int'(eol_err);
         cyc++;
      end
      in_stream_tvalid = 1'b0;
      pix_ready = 1'b0;
      chk({nm, "_in_time"}, 64'(cyc < budget), 64'd1);
   endtask

   function automatic scen_t mk(input string name, input int junk, input int cut, input int frames,
                                input int kill, input int drop_line, input int ready_pct,
                                input int gap_pct, input int ef, input int es, input int ee);
      scen_t s;
      s.name = name; s.junk = junk; s.cut = cut; s.frames = frames; s.kill = kill;
      s.drop_line = drop_line; s.ready_pct = ready_pct; s.gap_pct = gap_pct;
      s.exp_frames = ef; s.exp_sof = es; s.exp_eol = ee;
      return s;
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      scen_t sc[6];
      int    nmin;

      // ---------------- reset ----------------
      aresetn = 1'b0;
      repeat (3) tick();
      chk("rst_tready", 64'(in_stream_tready), 64'd0);
      chk("rst_pix_valid", 64'(pix_valid), 64'd0);
      aresetn = 1'b1;
      #1;
      chk("rel_outputs", {r, g, b, x, y, pix_valid, frame_done, sof_err, eol_err, frame_count}, 64'd0);
      chk("rel_tready", 64'(in_stream_tready), 64'd0);
      tick();
      chk("rel_tready_next", 64'(in_stream_tready), 64'd1);
      chk("rel_pix_valid_next", 64'(pix_valid), 64'd0);

      // ---------------- unpack + tready timing ----------------
      pix_ready = 1'b1;
      drive(32'h66112233, 1'b1, 1'b0, 1'b1);
      tick();
      chk("unp_p0", {r, g, b, x, y, pix_valid}, {24'h112233, 10'd0, 9'd0, 1'b1});
      drive(32'h88994455, 1'b0, 1'b0, 1'b1);
      tick();
      chk("unp_p1", {r, g, b, x, y, pix_valid}, {24'h445566, 10'd1, 9'd0, 1'b1});
      drive(32'hAABBCC77, 1'b0, 1'b0, 1'b1);
      tick();
      chk("unp_p2", {r, g, b, x, y, pix_valid}, {24'h778899, 10'd2, 9'd0, 1'b1});
      in_stream_tvalid = 1'b0;
      #1;
      chk("unp_tready_stall", 64'(in_stream_tready), 64'd0);
      tick();
      chk("unp_p3", {r, g, b, x, y, pix_valid}, {24'hAABBCC, 10'd3, 9'd0, 1'b1});
      chk("unp_tready_back", 64'(in_stream_tready), 64'd1);
      tick();
      chk("unp_drained", 64'(pix_valid), 64'd0);

      // ---------------- backpressure ----------------
      do_reset();
      pix_ready = 1'b1;
      drive(32'h66112233, 1'b1, 1'b0, 1'b1);
      tick();
      drive(32'h88994455, 1'b0, 1'b0, 1'b1);
      tick();
      pix_ready = 1'b0;
      drive(32'hAABBCC77, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         #1;
         chk($sformatf("bp_hold%0d", i), {in_stream_tready, pix_valid, r, g, b, x, y},
             {1'b0, 1'b1, 24'h445566, 10'd1, 9'd0});
         tick();
      end
      pix_ready = 1'b1;
      tick();
      in_stream_tvalid = 1'b0;
      chk("bp_p2", {r, g, b, x, y, pix_valid}, {24'h778899, 10'd2, 9'd0, 1'b1});
      tick();
      chk("bp_p3", {r, g, b, x, y, pix_valid}, {24'hAABBCC, 10'd3, 9'd0, 1'b1});
      tick();

      // ---------------- hunt: tuser=0 words are swallowed ----------------
      do_reset();
      pix_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         drive($urandom, 1'b0, 1'b0, 1'b1);
         #1;
         chk($sformatf("hunt_tready%0d", i), 64'(in_stream_tready), 64'd1);
         tick();
         chk($sformatf("hunt_nopix%0d", i), 64'(pix_valid), 64'd0);
      end
      drive(32'h00ABCDEF, 1'b1, 1'b0, 1'b1);
      tick();
      in_stream_tvalid = 1'b0;
      chk("hunt_first", {r, g, b, x, y, pix_valid}, {24'hABCDEF, 10'd0, 9'd0, 1'b1});
      tick();

      // ---------------- randomised scenario table ----------------
      //            name          junk cut  frm kill drop rdy gap  frames sof eol
      sc[0] = mk("clean_fast",  0,   -1,  1,  -1,  -1, 100, 0,   1,    0,  0);
      sc[1] = mk("clean_rand",  0,   -1,  3,  -1,  -1, 60,  30,  3,    0,  0);
      sc[2] = mk("hunt7",       7,   -1,  1,  -1,  -1, 80,  10,  1,    0,  0);
      sc[3] = mk("eol_drop",    0,   -1,  1,  -1,  5,  70,  20,  1,    0,  1);
      sc[4] = mk("sof_resync",  0,   100, 1,  -1,  -1, 75,  15,  1,    1,  0);
      sc[5] = mk("sof_missing", 0,   -1,  3,  1,   -1, 85,  10,  2,    1,  0);

      foreach (sc[s]) begin
         do_reset();
         tx_q.delete();
         exp_q.delete();
         add_junk(sc[s].junk);
         if (sc[s].cut >= 0) add_frame(sc[s].cut, 1'b0, -1, 1'b1);
         for (int f = 0; f < sc[s].frames; f++)
            add_frame(WPF, (f == sc[s].kill), (f == 0) ? sc[s].drop_line : -1, (f != sc[s].kill));
         run_stream(sc[s].name, sc[s].ready_pct, sc[s].gap_pct, 20 * (tx_q.size() + exp_q.size()) + 200);
         chk({sc[s].name, "_npix"}, 64'(got_q.size()), 64'(exp_q.size()));
         nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
         for (int i = 0; i < nmin; i++)
            chk($sformatf("%s_pix%0d", sc[s].name, i), 64'(got_q[i]), 64'(exp_q[i]));
         chk({sc[s].name, "_frame_done"}, 64'(cnt_fd), 64'(sc[s].exp_frames));
         chk({sc[s].name, "_frame_count"}, 64'(frame_count), 64'(sc[s].exp_frames));
         chk({sc[s].name, "_sof_err"}, 64'(cnt_sof), 64'(sc[s].exp_sof));
         chk({sc[s].name, "_eol_err"}, 64'(cnt_eol), 64'(sc[s].exp_eol));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
